// File: rtl/che_out_pkg.sv
// che_out_pkg: shared constants, tag positions and FSM state type for the CLAHE output framer
`ifndef DAT_PIX_WD
`define DAT_PIX_WD 8
`endif
`ifndef SIZ_FRA_X
`define SIZ_FRA_X 4
`endif
`ifndef SIZ_FRA_Y
`define SIZ_FRA_Y 2
`endif

package che_out_pkg;
    localparam int DAT_WD   = `DAT_PIX_WD;
    localparam int FRA_X    = `SIZ_FRA_X;
    localparam int FRA_Y    = `SIZ_FRA_Y;
    localparam int FIFO_DEP = 8;
    localparam int PTR_WD   = $clog2(FIFO_DEP) + 1;
    localparam int TAG_SOF  = 0;
    localparam int TAG_EOL  = 1;
    localparam int TAG_EOF  = 2;
    localparam int ENT_WD   = DAT_WD + 3;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/che_out_fifo.sv
// che_out_fifo: first-word fall-through synchronous FIFO with flush and MSB-compare full/empty
module che_out_fifo #(
    parameter int WD  = 11,
    parameter int DEP = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [WD-1:0] din,
    output logic [WD-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEP);
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [WD-1:0] mem [DEP];
    logic          wr_en;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && !flush && (!full || pop);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    // pointer update; a pop on a full FIFO frees the slot the concurrent push lands in
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage write; contents are masked by empty so they need no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/che_out_framer.sv
// che_out_framer: raster-tags the CLAHE pixel stream, buffers it in a FWFT FIFO and flags overflow; CHE_OUT_STAT_EN adds per-frame min/max
module che_out_framer #(
    parameter int DAT_WD     = che_out_pkg::DAT_WD,
    parameter int FRA_X      = che_out_pkg::FRA_X,
    parameter int FRA_Y      = che_out_pkg::FRA_Y,
    parameter int FIFO_DEP   = che_out_pkg::FIFO_DEP,
    parameter int FRM_CNT_WD = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    input  logic                  vld_i,
    input  logic [DAT_WD-1:0]     dat_i,
    output logic                  m_vld_o,
    input  logic                  m_rdy_i,
    output logic [DAT_WD-1:0]     m_dat_o,
    output logic                  m_sof_o,
    output logic                  m_eol_o,
    output logic                  m_eof_o,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic [FRM_CNT_WD-1:0] frm_cnt_o,
    output logic                  stat_vld_o,
    output logic [DAT_WD-1:0]     stat_min_o,
    output logic [DAT_WD-1:0]     stat_max_o
);
    import che_out_pkg::*;
    localparam int EW = DAT_WD + 3;
    localparam int XW = $clog2(FRA_X + 1);
    localparam int YW = $clog2(FRA_Y + 1);
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    state_t        state, state_nxt;
    logic          sof, eol, eof, take, pop, push, full, empty;
    logic [EW-1:0] ent, head;
    assign sof  = (x_cnt == '0) && (y_cnt == '0);
    assign eol  = x_cnt == XW'(FRA_X - 1);
    assign eof  = eol && (y_cnt == YW'(FRA_Y - 1));
    assign take = vld_i && !clr_i;
    assign pop  = !empty && m_rdy_i;
    assign push = take && (!full || pop);
    assign ent  = {eof, eol, sof, dat_i};
    assign m_vld_o = !empty;
    assign m_dat_o = head[DAT_WD-1:0];
    assign m_sof_o = head[DAT_WD+TAG_SOF];
    assign m_eol_o = head[DAT_WD+TAG_EOL];
    assign m_eof_o = head[DAT_WD+TAG_EOF];
    assign busy_o  = (state == ACTIVE) || (state == IDLE && vld_i);

    che_out_fifo #(.WD(EW), .DEP(FIFO_DEP)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (clr_i),
        .push  (push),
        .pop   (pop),
        .din   (ent),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // raster counters follow every upstream pixel, dropped or not, to stay aligned
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (clr_i) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (vld_i) begin
            x_cnt <= eol ? '0 : x_cnt + 1'b1;
            if (eol) y_cnt <= eof ? '0 : y_cnt + 1'b1;
        end
    end

    // frame FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // any pixel enters or continues a frame, the eof pixel closes it
    always_comb begin
        state_nxt = state;
        if (clr_i)      state_nxt = IDLE;
        else if (vld_i) state_nxt = eof ? IDLE : ACTIVE;
    end

    // sticky overflow on a drop, and completed-frame count that survives soft clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_o     <= 1'b0;
            frm_cnt_o <= '0;
        end else if (clr_i) begin
            ovf_o <= 1'b0;
        end else if (vld_i) begin
            if (full && !pop) ovf_o <= 1'b1;
            if (eof) frm_cnt_o <= frm_cnt_o + 1'b1;
        end
    end

`ifdef CHE_OUT_STAT_EN
    logic [DAT_WD-1:0] run_min, run_max, nxt_min, nxt_max;
    assign nxt_min = (sof || dat_i < run_min) ? dat_i : run_min;
    assign nxt_max = (sof || dat_i > run_max) ? dat_i : run_max;
    // running min/max over every input pixel, reseeded by sof and published on eof
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_min    <= '0;
            run_max    <= '0;
            stat_vld_o <= 1'b0;
            stat_min_o <= '0;
            stat_max_o <= '0;
        end else if (clr_i) begin
            run_min    <= '0;
            run_max    <= '0;
            stat_vld_o <= 1'b0;
        end else begin
            stat_vld_o <= vld_i && eof;
            if (vld_i) begin
                run_min <= nxt_min;
                run_max <= nxt_max;
            end
            if (vld_i && eof) begin
                stat_min_o <= nxt_min;
                stat_max_o <= nxt_max;
            end
        end
    end
`else
    assign stat_vld_o = 1'b0;
    assign stat_min_o = '0;
    assign stat_max_o = '0;
`endif
endmodule

// File: doc/che_out_framer.md
Name: che_out_framer

Overview:
- Output stage directly downstream of the CLAHE top (che_top); consumes its vld_o/dat_o pixel stream.
- Tracks raster position and tags each pixel with sof/eol/eof.
- Buffers pixels in a small FIFO and presents a ready/valid stream to the display/DMA sink.
- The CLAHE pipeline cannot be stalled, so the block detects and flags overflow instead of back-pressuring.

Parameters:
- DAT_WD, `DAT_PIX_WD: pixel width.
- FRA_X, `SIZ_FRA_X: pixels per line.
- FRA_Y, `SIZ_FRA_Y: lines per frame.
- FIFO_DEP, 8: FIFO entries; power of two, ≥2.
- FRM_CNT_WD, 16: frame counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset. Asynchronous, active-low.
- clr_i  in  1  synchronous soft clear; single-cycle pulse.
- vld_i  in  1  pixel valid from CLAHE output.
- dat_i  in  DAT_WD  pixel from CLAHE output.
- m_vld_o  out  1  output valid.
- m_rdy_i  in  1  sink ready.
- m_dat_o  out  DAT_WD  output pixel.
- m_sof_o  out  1  first pixel of frame.
- m_eol_o  out  1  last pixel of line.
- m_eof_o  out  1  last pixel of frame.
- busy_o  out  1  high while a frame is in progress.
- ovf_o  out  1  sticky overflow.
- frm_cnt_o  out  FRM_CNT_WD  completed-frame count.
- stat_vld_o  out  1  frame statistics valid pulse (optional feature).
- stat_min_o  out  DAT_WD  frame minimum (optional feature).
- stat_max_o  out  DAT_WD  frame maximum (optional feature).

Behaviour:
- Reset (rstn low, async) clears everything: x_cnt=0, y_cnt=0, FSM=IDLE, FIFO empty, frm_cnt_o=0, ovf_o=0, busy_o=0.
- Reset drives all m_* outputs and all stat_* outputs to 0.
- Counters:
  - x_cnt increments on every vld_i and wraps at FRA_X-1.
  - y_cnt increments on x wrap and wraps at FRA_Y-1.
  - Counters advance even when the pixel is dropped, so framing stays aligned to the upstream raster.
- Tags per pixel:
  - sof = (x==0 && y==0).
  - eol = (x==FRA_X-1).
  - eof = eol && (y==FRA_Y-1).
  - Entry stored is {eof,eol,sof,dat_i}.
- FSM:
  - IDLE → ACTIVE on vld_i.
  - ACTIVE → IDLE on the vld_i that carries eof, regardless of whether it is dropped.
  - busy_o = (state==ACTIVE) or (state==IDLE && vld_i). This is combinational on the entry cycle; the IDLE/eof case is covered below.
  - frm_cnt_o increments (wrapping) on each eof input pixel.
  - FRA_X=FRA_Y=1 is legal: every pixel is sof/eol/eof and the FSM stays IDLE.
- FIFO:
  - First-word fall-through. m_vld_o = !empty; m_dat_o and the tag outputs show the head entry.
  - Pop when m_vld_o && m_rdy_i.
  - Latency: pixel pushed at cycle N is visible at m_vld_o in cycle N+1 (registered storage).
  - m_dat_o and the tags hold stable while m_vld_o && !m_rdy_i.
- Push/pop corner cases:
  - Full with pop in the same cycle: push accepted; occupancy unchanged.
  - Full without pop: pixel dropped and ovf_o set to 1. ovf_o is sticky until clr_i or reset.
  - Empty with push and no pop: no bypass; data appears the next cycle.
  - Pointers are log2(FIFO_DEP)+1 bits, wrap naturally, with an MSB-compare full/empty test.
- clr_i:
  - Next edge: counters=0, FSM=IDLE, FIFO flushed, ovf_o=0.
  - frm_cnt_o is retained.
  - A vld_i coinciding with clr_i is discarded.
  - clr_i has priority over every other event.

Optional Feature:
- Macro CHE_OUT_STAT_EN.
- Defined:
  - Running min/max are tracked over all input pixels of a frame, including dropped ones. The sof pixel re-seeds both.
  - On the eof pixel, stat_min_o/stat_max_o register the final values (including that pixel), and stat_vld_o pulses high for 1 cycle in the next cycle.
  - Outputs hold until the next eof.
  - clr_i clears the running values.
- Undefined: the stat ports exist but are tied to 0, and no min/max logic is built.

Decomposition:
- Package che_out_pkg holds:
  - constants FRA_X, FRA_Y, FIFO_DEP, PTR_WD = log2(FIFO_DEP)+1;
  - tag bit positions TAG_SOF=0, TAG_EOL=1, TAG_EOF=2;
  - entry width ENT_WD = DAT_WD+3.
- Sub-module che_out_fifo: generic FWFT synchronous FIFO (ENT_WD, FIFO_DEP) with push/pop/full/empty and flush.
- Counters, FSM and stats stay in the top.

Test Plan (FRA_X=4, FRA_Y=2, FIFO_DEP=4, DAT_WD=8):
- Frame flow, m_rdy_i=1: 8 continuous vld_i with data 0x10..0x17 → outputs appear 1 cycle later. Tags: sof on 0x10, eol on 0x13 and 0x17, eof on 0x17. frm_cnt_o=1, busy_o low after eof, ovf_o=0.
- Back-pressure: m_rdy_i=0 for 4 pushes of 0xA0..0xA3, then the 5th pixel 0xA4 → FIFO full, 0xA4 dropped, ovf_o=1. Release m_rdy_i → 0xA0..0xA3 drain in order, stable while stalled. The next frame's sof is still at its correct raster position.
- Full+pop same cycle: FIFO full, m_rdy_i=1 and vld_i=1 together → push accepted, ovf_o stays 0, occupancy stays 4.
- Soft clear mid-frame: clr_i after 3 pixels, with vld_i=1 (0x55) in the same cycle → FIFO empty, m_vld_o=0 next cycle, 0x55 discarded. The next pixel carries sof; frm_cnt_o is unchanged.
- Async reset mid-frame: rstn low for 1 cycle, asserted between clock edges → all outputs 0 immediately. Restart produces sof on the first pixel.
- CHE_OUT_STAT_EN: frame data {0x30,0x05,0xF0,0x40,0x41,0x42,0x43,0x44} → stat_min_o=0x05, stat_max_o=0xF0, stat_vld_o one-cycle pulse one cycle after the eof input.
